// File: rtl/axis_packet_capture.sv
// AXI-stream sink that captures one whole packet into a beat buffer, holds it with
// its metadata until acknowledged, and exposes the stored beats on a registered read port.
module axis_packet_capture #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic [DATA_WIDTH/8-1:0]                in_keep,
  input  logic [DEST_WIDTH-1:0]                  in_dest,
  input  logic [USER_WIDTH-1:0]                  in_user,
  input  logic                                   in_last,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic                                   pkt_valid,
  output logic [$clog2(DEPTH):0]                 pkt_beats,
  output logic [$clog2(DEPTH*DATA_WIDTH/8):0]    pkt_bytes,
  output logic [DEST_WIDTH-1:0]                  pkt_dest,
  output logic [USER_WIDTH-1:0]                  pkt_user,
  output logic [1:0]                             pkt_err,
  input  logic                                   pkt_ack,
  input  logic [$clog2(DEPTH)-1:0]               rd_addr,
  output logic [DATA_WIDTH-1:0]                  rd_data,
  output logic [DATA_WIDTH/8-1:0]                rd_keep
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned BW     = AW + 1;
  localparam int unsigned BYW    = $clog2(DEPTH * KEEP_W) + 1;

  typedef enum logic [1:0] {RECV, DISCARD, HOLD} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]         pkt_beats_q, pkt_beats_d;
  logic [BYW-1:0]        pkt_bytes_q, pkt_bytes_d;
  logic [DEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;
  logic [USER_WIDTH-1:0] pkt_user_q, pkt_user_d;
  logic [1:0]            pkt_err_q, pkt_err_d;
  logic                  in_ready_q, in_ready_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [KEEP_W-1:0]     rd_keep_q, rd_keep_d;
  logic                  xfer;
  logic                  wr_en;
  logic                  keep_ok;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [KEEP_W-1:0]     mem_keep [DEPTH];

  function automatic logic [BYW-1:0] popcount(input logic [KEEP_W-1:0] k);
    logic [BYW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(KEEP_W); i++) n = n + BYW'(k[i]);
    return n;
  endfunction

  assign xfer    = in_valid && in_ready_q;
  // Legal keep is a nonzero run of ones starting at bit 0.
  assign keep_ok = (in_keep != '0) && ((in_keep & (in_keep + KEEP_W'(1))) == '0);

  // Next-state and metadata update.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_beats_d = pkt_beats_q;
    pkt_bytes_d = pkt_bytes_q;
    pkt_dest_d  = pkt_dest_q;
    pkt_user_d  = pkt_user_q;
    pkt_err_d   = pkt_err_q;
    wr_en       = 1'b0;
    rd_data_d   = mem_data[rd_addr];
    rd_keep_d   = mem_keep[rd_addr];

    case (state_q)
      RECV: begin
        if (xfer) begin
          wr_en       = 1'b1;
          wr_ptr_d    = wr_ptr_q + AW'(1);
          pkt_beats_d = pkt_beats_q + BW'(1);
          pkt_bytes_d = pkt_bytes_q + popcount(in_keep);
          if (pkt_beats_q == '0) begin
            pkt_dest_d = in_dest;
            pkt_user_d = in_user;
          end
          if (!keep_ok) pkt_err_d[1] = 1'b1;
          if (in_last) begin
            state_d = HOLD;
          end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
            pkt_err_d[0] = 1'b1;
            state_d      = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (xfer && in_last) state_d = HOLD;
      end
      HOLD: begin
        if (pkt_ack) begin
          state_d     = RECV;
          wr_ptr_d    = '0;
          pkt_beats_d = '0;
          pkt_bytes_d = '0;
          pkt_dest_d  = '0;
          pkt_user_d  = '0;
          pkt_err_d   = '0;
        end
      end
      default: state_d = RECV;
    endcase

    // Ready follows next-state so no beat slips in after the last one.
    in_ready_d  = (state_d != HOLD);
    pkt_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RECV;
      wr_ptr_q    <= '0;
      pkt_beats_q <= '0;
      pkt_bytes_q <= '0;
      pkt_dest_q  <= '0;
      pkt_user_q  <= '0;
      pkt_err_q   <= '0;
      in_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      rd_data_q   <= '0;
      rd_keep_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pkt_beats_q <= pkt_beats_d;
      pkt_bytes_q <= pkt_bytes_d;
      pkt_dest_q  <= pkt_dest_d;
      pkt_user_q  <= pkt_user_d;
      pkt_err_q   <= pkt_err_d;
      in_ready_q  <= in_ready_d;
      pkt_valid_q <= pkt_valid_d;
      rd_data_q   <= rd_data_d;
      rd_keep_q   <= rd_keep_d;
    end
  end

  // Beat buffer; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_keep[wr_ptr_q] <= in_keep;
    end
  end

  assign in_ready  = in_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_beats = pkt_beats_q;
  assign pkt_bytes = pkt_bytes_q;
  assign pkt_dest  = pkt_dest_q;
  assign pkt_user  = pkt_user_q;
  assign pkt_err   = pkt_err_q;
  assign rd_data   = rd_data_q;
  assign rd_keep   = rd_keep_q;

endmodule

// File: tb/tb_axis_packet_capture.sv
// Directed plus randomized packet bench for axis_packet_capture with a small DEPTH
// so truncation is reachable; expectations come from a per-packet model.
module tb_axis_packet_capture;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [7:0]    in_keep;
  logic [7:0]    in_dest;
  logic [7:0]    in_user;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic          pkt_valid;
  logic [2:0]    pkt_beats;
  logic [5:0]    pkt_bytes;
  logic [7:0]    pkt_dest;
  logic [7:0]    pkt_user;
  logic [1:0]    pkt_err;
  logic          pkt_ack;
  logic [1:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    rd_keep;

  axis_packet_capture #(.DATA_WIDTH(DW), .DEST_WIDTH(8), .USER_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_keep(in_keep), .in_dest(in_dest), .in_user(in_user),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .pkt_valid(pkt_valid), .pkt_beats(pkt_beats), .pkt_bytes(pkt_bytes),
    .pkt_dest(pkt_dest), .pkt_user(pkt_user), .pkt_err(pkt_err), .pkt_ack(pkt_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_keep(rd_keep)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Current packet as the source sees it.
  logic [DW-1:0] pd [16];
  logic [7:0]    pk [16];
  int            pn;
  logic [7:0]    pdest, puser;
  int            ack_at = -1;
  bit            gaps   = 1'b0;
  int            n_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_keep(input logic [7:0] k);
    for (int m = 1; m <= 8; m++) if (int'(k) == (1 << m) - 1) return 1'b1;
    return 1'b0;
  endfunction

  // Drive beats 0..n_send-1 of the current packet; entered and left on a negedge.
  task automatic drive(input int n_send);
    int i, cyc;
    bit hs, prev_hs;
    i = 0; cyc = 0; n_hs = 0; prev_hs = 1'b0;
    while (i < n_send && cyc < 200) begin
      if (gaps && prev_hs && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      in_valid = 1'b1;
      in_data  = pd[i];
      in_keep  = pk[i];
      in_last  = (i == pn - 1);
      in_dest  = pdest;
      in_user  = puser;
      pkt_ack  = (i == ack_at);
      hs       = in_ready;
      @(posedge clk); @(negedge clk);
      cyc++;
      prev_hs = hs;
      if (hs) begin i++; n_hs++; end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    pkt_ack  = 1'b0;
    check("drive_done", 64'(i == n_send), 64'd1);
  endtask

  // Compare held metadata and buffer contents against the packet model.
  task automatic check_pkt(input string tag);
    int nst, bytes;
    bit bad;
    nst = (pn < int'(DEPTH)) ? pn : int'(DEPTH);
    bytes = 0; bad = 1'b0;
    for (int j = 0; j < nst; j++) begin
      bytes += $countones(pk[j]);
      if (!legal_keep(pk[j])) bad = 1'b1;
    end
    check({tag, "_valid"}, 64'(pkt_valid), 64'd1);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_beats"}, 64'(pkt_beats), 64'(nst));
    check({tag, "_bytes"}, 64'(pkt_bytes), 64'(bytes));
    check({tag, "_dest"}, 64'(pkt_dest), 64'(pdest));
    check({tag, "_user"}, 64'(pkt_user), 64'(puser));
    check({tag, "_err"}, 64'(pkt_err), 64'({bad, pn > int'(DEPTH)}));
    for (int j = 0; j < nst; j++) begin
      rd_addr = 2'(j);
      @(posedge clk); @(negedge clk);
      check({tag, "_rdata"}, rd_data, pd[j]);
      check({tag, "_rkeep"}, 64'(rd_keep), 64'(pk[j]));
    end
  endtask

  task automatic do_ack(input string tag);
    pkt_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    pkt_ack = 1'b0;
    check({tag, "_ack_valid"}, 64'(pkt_valid), 64'd0);
    check({tag, "_ack_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_ack_beats"}, 64'(pkt_beats), 64'd0);
    check({tag, "_ack_bytes"}, 64'(pkt_bytes), 64'd0);
    check({tag, "_ack_err"}, 64'(pkt_err), 64'd0);
  endtask

  task automatic new_pkt(input int n, input logic [7:0] d, input logic [7:0] u);
    pn = n; pdest = d; puser = u;
    for (int j = 0; j < n; j++) begin
      pd[j] = {$urandom, $urandom};
      pk[j] = 8'hFF;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_keep = '0;
    in_dest = '0; in_user = '0; pkt_ack = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_beats", 64'(pkt_beats), 64'd0);
    check("rst_bytes", 64'(pkt_bytes), 64'd0);
    check("rst_err", 64'(pkt_err), 64'd0);
    check("rst_rdata", rd_data, 64'd0);
    check("rst_rkeep", 64'(rd_keep), 64'd0);
    rst = 1'b0;
    check("rel_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("rel_ready_high", 64'(in_ready), 64'd1);

    // 3-beat packet FF/FF/0F
    new_pkt(3, 8'h12, 8'h05);
    pk[2] = 8'h0F;
    drive(3);
    check_pkt("p3");

    // Second packet offered while holding: nothing consumed until ack
    new_pkt(2, 8'h34, 8'h07);
    pk[1] = 8'h3F;
    in_valid = 1'b1; in_data = pd[0]; in_keep = pk[0]; in_last = 1'b0;
    in_dest = pdest; in_user = puser;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_beats", 64'(pkt_beats), 64'd3);
    end
    do_ack("hold");
    drive(2);
    check("p2_hs", 64'(n_hs), 64'd2);
    check_pkt("p2");
    do_ack("p2");

    // Overflow: 6 beats into 4 slots
    new_pkt(6, 8'hA0, 8'h01);
    drive(6);
    check("ovf_hs", 64'(n_hs), 64'd6);
    check_pkt("ovf");
    do_ack("ovf");

    // Illegal keep 0x05 on a single beat, then 0x00 on a last beat
    new_pkt(1, 8'h01, 8'h02);
    pk[0] = 8'h05;
    drive(1);
    check_pkt("k05");
    do_ack("k05");
    new_pkt(2, 8'h03, 8'h04);
    pk[1] = 8'h00;
    drive(2);
    check_pkt("k00");
    do_ack("k00");

    // Reset after 2 of 4 beats
    new_pkt(4, 8'h55, 8'h66);
    drive(2);
    check("mid_beats", 64'(pkt_beats), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_valid", 64'(pkt_valid), 64'd0);
    check("mid_rst_beats", 64'(pkt_beats), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    new_pkt(1, 8'h77, 8'h88);
    pk[0] = 8'h01;
    drive(1);
    check_pkt("post_rst");
    do_ack("post_rst");

    // Ack pulsed mid-packet in RECV is ignored
    new_pkt(4, 8'h99, 8'hAA);
    pk[3] = 8'h07;
    ack_at = 1;
    drive(4);
    ack_at = -1;
    check_pkt("ack_recv");
    do_ack("ack_recv");

    // Randomized packets with idle gaps
    gaps = 1'b1;
    for (int t = 0; t < 12; t++) begin
      new_pkt(int'($urandom_range(1, 6)), 8'($urandom), 8'($urandom));
      for (int j = 0; j < pn; j++) begin
        if ($urandom_range(0, 3) != 0) pk[j] = 8'((1 << $urandom_range(1, 8)) - 1);
        else pk[j] = 8'($urandom);
      end
      drive(pn);
      check("rnd_hs", 64'(n_hs), 64'(pn));
      check_pkt("rnd");
      do_ack("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
